// File: rtl/soc_gpio_arbiter.sv
// Two-requester round-robin arbiter in front of a single GPIO register port.
// Each access is bounded by a wait-cycle timeout.
module soc_gpio_arbiter #(
  parameter int unsigned IO_MAP_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned TIMEOUT      = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m0_req,
  input  logic                    m0_we,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  input  logic [IO_MAP_WIDTH-1:0] m0_wdata,
  output logic                    m0_ack,
  output logic [IO_MAP_WIDTH-1:0] m0_rdata,
  output logic                    m0_err,
  input  logic                    m1_req,
  input  logic                    m1_we,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic [IO_MAP_WIDTH-1:0] m1_wdata,
  output logic                    m1_ack,
  output logic [IO_MAP_WIDTH-1:0] m1_rdata,
  output logic                    m1_err,
  output logic                    gpio_valid,
  output logic                    gpio_we,
  output logic [ADDR_WIDTH-1:0]   gpio_addr,
  output logic [IO_MAP_WIDTH-1:0] gpio_wdata,
  input  logic [IO_MAP_WIDTH-1:0] gpio_rdata,
  input  logic                    gpio_ready,
  output logic                    arb_busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_e     state_q;
  logic       last_grant_q;
  logic       grant_q;
  logic [7:0] wait_cnt_q;
  logic       grant_m1;
  logic       finish;
  logic [IO_MAP_WIDTH-1:0] rdata_cap;

  // On contention the requester not served last time wins.
  assign grant_m1  = m1_req & (~m0_req | ~last_grant_q);
  assign finish    = gpio_ready | (wait_cnt_q == TimeoutCnt);
  // The gpio port registers double as the holding registers for the access.
  assign rdata_cap = (gpio_ready && !gpio_we) ? gpio_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      wait_cnt_q   <= '0;
      m0_ack       <= 1'b0;
      m0_rdata     <= '0;
      m0_err       <= 1'b0;
      m1_ack       <= 1'b0;
      m1_rdata     <= '0;
      m1_err       <= 1'b0;
      gpio_valid   <= 1'b0;
      gpio_we      <= 1'b0;
      gpio_addr    <= '0;
      gpio_wdata   <= '0;
      arb_busy     <= 1'b0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (m0_req || m1_req) begin
            grant_q    <= grant_m1;
            gpio_valid <= 1'b1;
            gpio_we    <= grant_m1 ? m1_we : m0_we;
            gpio_addr  <= grant_m1 ? m1_addr : m0_addr;
            gpio_wdata <= grant_m1 ? m1_wdata : m0_wdata;
            wait_cnt_q <= '0;
            arb_busy   <= 1'b1;
            state_q    <= StAccess;
          end
        end
        StAccess: begin
          if (finish) begin
            gpio_valid <= 1'b0;
            gpio_we    <= 1'b0;
            state_q    <= StDone;
            if (grant_q) begin
              m1_ack   <= 1'b1;
              m1_err   <= ~gpio_ready;
              m1_rdata <= rdata_cap;
            end else begin
              m0_ack   <= 1'b1;
              m0_err   <= ~gpio_ready;
              m0_rdata <= rdata_cap;
            end
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        StDone: begin
          last_grant_q <= grant_q;
          arb_busy     <= 1'b0;
          state_q      <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
